ifu_pc_ctrl: RTL and testbench

- Instruction-fetch PC controller for the scpu core: owns the architectural PC, issues fetch requests to instruction memory over a valid/ready handshake, and presents one fetched instruction at a time to decode.
- Sits directly upstream of the CSR unit. It consumes the CSR unit's trap/return target (mtvec on ecall, mepc on mret) and the branch unit's target to select the next PC.
- Supplies the pc that the CSR unit saves into mepc.

---
 rtl/ifu_pc_ctrl_if.sv | 34 +++
 rtl/ifu_pc_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ifu_pc_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pc_ctrl_if.sv
// Signal bundle between the IFU PC controller (master) and its imem, decode,
// CSR and branch neighbours (slave).
interface ifu_pc_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [31:0]     resp_inst;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            csr_trap;
  logic [XLEN-1:0] csr_pc;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            misalign_err;

  modport master (
    output req_valid, req_addr, inst_valid, inst, pc, misalign_err,
    input  req_ready, resp_valid, resp_inst, inst_ready,
           csr_trap, csr_pc, br_taken, br_target, flush, flush_pc
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, pc, misalign_err,
    output req_ready, resp_valid, resp_inst, inst_ready,
           csr_trap, csr_pc, br_taken, br_target, flush, flush_pc
  );
endinterface

// File: rtl/ifu_pc_ctrl.sv
// Instruction-fetch PC controller: one outstanding imem request, one instruction presented to decode.
// Define IFU_MISALIGN_CHECK_EN to trap misaligned next-PCs into a sticky ERR state.
module ifu_pc_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  ifu_pc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3
`ifdef IFU_MISALIGN_CHECK_EN
    , ERR = 3'd4
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            req_valid_q, req_valid_d;
  logic            inst_valid_q, inst_valid_d;
  logic [31:0]     inst_q, inst_d;
  logic            kill_q, kill_d;
`ifdef IFU_MISALIGN_CHECK_EN
  logic            err_q, err_d;
`endif
  logic [XLEN-1:0] retire_pc_d;
  logic [XLEN-1:0] launch_addr;
  logic            launch;

  function automatic logic [XLEN-1:0] sel_next_pc(
    input logic            trap,
    input logic [XLEN-1:0] trap_pc,
    input logic            br,
    input logic [XLEN-1:0] br_pc,
    input logic [XLEN-1:0] cur_pc
  );
    if (trap) return trap_pc;
    if (br)   return br_pc;
    return cur_pc + XLEN'(4);
  endfunction

  assign retire_pc_d = sel_next_pc(bus.csr_trap, bus.csr_pc, bus.br_taken,
                                   bus.br_target, pc_q);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    req_valid_d  = req_valid_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    kill_d       = kill_q;
`ifdef IFU_MISALIGN_CHECK_EN
    err_d        = err_q;
`endif
    launch       = 1'b0;
    launch_addr  = pc_q;

    case (state_q)
      IDLE: begin
        launch = 1'b1;
        if (bus.flush) begin
          pc_d        = bus.flush_pc;
          launch_addr = bus.flush_pc;
        end
      end

      // A flush here cannot cancel the request already on the bus, so its
      // response is marked for discard instead.
      REQ: begin
        if (bus.req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end
        if (bus.flush) begin
          pc_d   = bus.flush_pc;
          kill_d = 1'b1;
        end
      end

      WAIT: begin
        if (bus.resp_valid) begin
          if (bus.flush) begin
            pc_d        = bus.flush_pc;
            kill_d      = 1'b0;
            launch      = 1'b1;
            launch_addr = bus.flush_pc;
          end else if (kill_q) begin
            kill_d      = 1'b0;
            launch      = 1'b1;
            launch_addr = pc_q;
          end else begin
            inst_d       = bus.resp_inst;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (bus.flush) begin
          pc_d   = bus.flush_pc;
          kill_d = 1'b1;
        end
      end

      HOLD: begin
        if (bus.flush) begin
          pc_d         = bus.flush_pc;
          inst_valid_d = 1'b0;
          launch       = 1'b1;
          launch_addr  = bus.flush_pc;
        end else if (bus.inst_ready) begin
          pc_d         = retire_pc_d;
          inst_valid_d = 1'b0;
          launch       = 1'b1;
          launch_addr  = retire_pc_d;
        end
      end

`ifdef IFU_MISALIGN_CHECK_EN
      ERR: begin
        if (bus.flush) begin
          pc_d        = bus.flush_pc;
          launch      = 1'b1;
          launch_addr = bus.flush_pc;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    // Every path toward a new fetch funnels through here so the alignment
    // check sees all next-PC sources alike.
    if (launch) begin
`ifdef IFU_MISALIGN_CHECK_EN
      if (launch_addr[1:0] != 2'b00) begin
        state_d     = ERR;
        req_valid_d = 1'b0;
        err_d       = 1'b1;
      end else begin
        state_d     = REQ;
        req_valid_d = 1'b1;
        req_addr_d  = launch_addr;
        err_d       = 1'b0;
      end
`else
      state_d     = REQ;
      req_valid_d = 1'b1;
      req_addr_d  = launch_addr;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      kill_q       <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      kill_q       <= kill_d;
`ifdef IFU_MISALIGN_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign bus.req_valid  = req_valid_q;
  assign bus.req_addr   = req_addr_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.pc         = pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
  assign bus.misalign_err = err_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_pc_ctrl.sv
// Scoreboard bench for ifu_pc_ctrl: an imem model, a next-presented-PC reference model and a monitor.
module tb_ifu_pc_ctrl;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifu_pc_ctrl_if #(.XLEN(32)) bus ();

  ifu_pc_ctrl #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // stimulus knobs
  bit          rand_mode = 1'b0;
  bit          hold_rdy  = 1'b0;
  int          rdy_pct = 100, ir_pct = 100, lat_min = 0, lat_max = 0;
  logic        d_trap = 1'b0, d_br = 1'b0, d_flush = 1'b0;
  logic [31:0] d_csr = '0, d_tgt = '0, d_fpc = '0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;

  // imem model
  bit          outst = 1'b0;
  logic [31:0] oaddr = '0;
  int          wcnt = 0;
  logic [31:0] acc_q[$];

  // reference model: the queue holds the PC of the next instruction decode must see
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc = '0;
  bit          mdl_err = 1'b0;
  bit          mon_en = 1'b0;
  int          n_pres = 0, n_dead = 0, cyc = 0;
  int          pres_cyc[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return 32'hBAD0_BAD1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic model_redirect(input logic [31:0] nxt, input bit is_flush);
    if (is_flush) exp_q.delete();
`ifdef IFU_MISALIGN_CHECK_EN
    if (nxt[1:0] != 2'b00) begin
      mdl_err = 1'b1;
      return;
    end
    mdl_err = 1'b0;
`endif
    exp_q.push_back(nxt);
  endtask

  task automatic drive_cycle();
    @(negedge clk);
    bus.resp_valid = 1'b0;
    if (outst) begin
      if (wcnt == 0) begin
        bus.resp_valid = 1'b1;
        bus.resp_inst  = ovr_en ? ovr_val : mem(oaddr);
        ovr_en = 1'b0;
        outst  = 1'b0;
      end else begin
        wcnt--;
      end
    end
    bus.req_ready = !hold_rdy && ($urandom_range(99) < rdy_pct);
    if (bus.req_valid && bus.req_ready) begin
      outst = 1'b1;
      oaddr = bus.req_addr;
      wcnt  = $urandom_range(lat_max, lat_min);
      acc_q.push_back(bus.req_addr);
    end
    bus.inst_ready = ($urandom_range(99) < ir_pct);
    if (rand_mode) begin
      bus.csr_trap  = ($urandom_range(99) < 15);
      bus.csr_pc    = $urandom & ~32'h3;
      bus.br_taken  = ($urandom_range(99) < 25);
      bus.br_target = $urandom & ~32'h3;
      bus.flush     = ($urandom_range(99) < 3);
      bus.flush_pc  = $urandom & ~32'h3;
    end else begin
      bus.csr_trap  = d_trap;
      bus.csr_pc    = d_csr;
      bus.br_taken  = d_br;
      bus.br_target = d_tgt;
      bus.flush     = d_flush;
      bus.flush_pc  = d_fpc;
    end
    if (bus.flush)
      model_redirect(bus.flush_pc, 1'b1);
    else if (bus.inst_valid && bus.inst_ready)
      model_redirect(bus.csr_trap ? bus.csr_pc : bus.br_taken ? bus.br_target : cur_pc + 32'd4, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.inst_ready = 1'b0;
    bus.flush = 1'b0; bus.csr_trap = 1'b0; bus.br_taken = 1'b0;
    outst = 1'b0; mdl_err = 1'b0;
    exp_q.delete();
    #1;
    check("rst_req_valid",  32'(bus.req_valid), 32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst",       bus.inst, 32'd0);
    check("rst_pc",         bus.pc, RESET_PC);
    check("rst_req_addr",   bus.req_addr, RESET_PC);
    check("rst_misalign",   32'(bus.misalign_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(RESET_PC);
    mon_en = 1'b1;
    rst = 1'b0;
  endtask

  task automatic run_until_iv(input string name);
    int n = 0;
    do begin
      drive_cycle();
      n++;
    end while (!bus.inst_valid && n < 60);
    if (!bus.inst_valid) timeout(name);
  endtask

  task automatic run_until_acc(input int want, input string name);
    int n = 0;
    while (acc_q.size() < want && n < 60) begin
      drive_cycle();
      n++;
    end
    if (acc_q.size() < want) timeout(name);
  endtask

  // monitor: pops the scoreboard whenever a new instruction is presented
  initial begin
    bit prev_iv = 1'b0;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst || !mon_en) begin
        prev_iv = 1'b0;
        continue;
      end
      check("misalign_err", 32'(bus.misalign_err), 32'(mdl_err));
      if (bus.inst_valid && !prev_iv) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_inst");
        end else begin
          e = exp_q.pop_front();
          cur_pc = e;
          n_pres++;
          pres_cyc.push_back(cyc);
          if (bus.inst == 32'hDEAD_BEEF) n_dead++;
          check("inst_pc", bus.pc, e);
          check("inst_word", bus.inst, mem(e));
        end
      end else if (bus.inst_valid) begin
        check("hold_pc", bus.pc, cur_pc);
        check("hold_inst", bus.inst, mem(cur_pc));
      end
      prev_iv = bus.inst_valid;
    end
  end

  // imem is only allowed to answer while the controller waits
  always @(posedge clk)
    if (mon_en && !rst)
      assert (!(bus.resp_valid && bus.req_valid)) else $error("resp_valid while request pending");

  initial begin
    logic [31:0] a;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_inst = '0;
    bus.inst_ready = 1'b0; bus.csr_trap = 1'b0; bus.csr_pc = '0;
    bus.br_taken = 1'b0; bus.br_target = '0; bus.flush = 1'b0; bus.flush_pc = '0;

    do_reset();

    // sequential fetch with a zero-wait imem
    acc_q.delete();
    pres_cyc.delete();
    repeat (12) drive_cycle();
    check("seq_addr0", acc_at(0), 32'h8000_0000);
    check("seq_addr1", acc_at(1), 32'h8000_0004);
    check("seq_addr2", acc_at(2), 32'h8000_0008);
    if (pres_cyc.size() < 3) timeout("seq_presentations");
    else begin
      check("seq_spacing0", 32'(pres_cyc[1] - pres_cyc[0]), 32'd3);
      check("seq_spacing1", 32'(pres_cyc[2] - pres_cyc[1]), 32'd3);
    end

    // trap target beats branch target
    ir_pct = 0;
    run_until_iv("trap_wait");
    d_trap = 1'b1; d_csr = 32'h8000_1000; d_br = 1'b1; d_tgt = 32'h8000_0200;
    ir_pct = 100;
    acc_q.delete();
    drive_cycle();
    d_trap = 1'b0; d_br = 1'b0;
    run_until_acc(1, "trap_req");
    check("trap_over_branch", acc_at(0), 32'h8000_1000);

    // pc+4 wraps at the top of the address space
    ir_pct = 0;
    run_until_iv("wrap_wait");
    acc_q.delete();
    d_flush = 1'b1; d_fpc = 32'hFFFF_FFFC;
    drive_cycle();
    d_flush = 1'b0;
    run_until_iv("wrap_fetch");
    check("wrap_flush_addr", acc_at(0), 32'hFFFF_FFFC);
    acc_q.delete();
    ir_pct = 100;
    run_until_acc(1, "wrap_req");
    check("wrap_addr", acc_at(0), 32'h0000_0000);

    // flush in WAIT; stale response arrives two cycles later
    ir_pct = 0;
    run_until_iv("killw_wait");
    lat_min = 2; lat_max = 2;
    acc_q.delete();
    ir_pct = 100;
    drive_cycle();
    ir_pct = 0;
    run_until_acc(1, "killw_req");
    ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
    acc_q.delete();
    d_flush = 1'b1; d_fpc = 32'h8000_0400;
    drive_cycle();
    d_flush = 1'b0;
    lat_min = 0; lat_max = 0;
    run_until_iv("killw_refetch");
    check("killw_addr", acc_at(0), 32'h8000_0400);
    check("killw_no_stale", 32'(n_dead), 32'd0);

    // imem stalls the request; flush lands in the second stalled cycle
    a = cur_pc + 32'd4;
    hold_rdy = 1'b1;
    acc_q.delete();
    ir_pct = 100;
    drive_cycle();
    ir_pct = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin d_flush = 1'b1; d_fpc = 32'h8000_0800; end
      drive_cycle();
      d_flush = 1'b0;
      check("stall_addr", bus.req_addr, a);
      check("stall_valid", 32'(bus.req_valid), 32'd1);
    end
    hold_rdy = 1'b0;
    run_until_acc(2, "stall_reqs");
    check("stall_first", acc_at(0), a);
    check("stall_second", acc_at(1), 32'h8000_0800);
    run_until_iv("stall_fetch");

`ifdef IFU_MISALIGN_CHECK_EN
    // misaligned branch target parks in ERR until an aligned flush
    d_br = 1'b1; d_tgt = 32'h8000_0002;
    ir_pct = 100;
    drive_cycle();
    d_br = 1'b0;
    ir_pct = 0;
    repeat (4) begin
      drive_cycle();
      check("err_flag", 32'(bus.misalign_err), 32'd1);
      check("err_no_req", 32'(bus.req_valid), 32'd0);
      check("err_pc", bus.pc, 32'h8000_0002);
    end
    d_flush = 1'b1; d_fpc = 32'h8000_0010;
    drive_cycle();
    d_flush = 1'b0;
    drive_cycle();
    check("err_cleared", 32'(bus.misalign_err), 32'd0);
    check("err_req_valid", 32'(bus.req_valid), 32'd1);
    check("err_req_addr", bus.req_addr, 32'h8000_0010);
    run_until_iv("err_refetch");
`endif

    // randomized traffic, with a reset in the middle
    rand_mode = 1'b1;
    rdy_pct = 70; lat_min = 0; lat_max = 3; ir_pct = 60;
    repeat (2500) drive_cycle();
    rand_mode = 1'b0;
    do_reset();
    rand_mode = 1'b1;
    repeat (2500) drive_cycle();
    rand_mode = 1'b0;
    check("progress", 32'(n_pres > 300), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
